// File: rtl/gray_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_frame_loader                                                          |
// | RGB stream -> 8-bit luma -> image memory writes; done_o starts the Sobel.  |
// | Optional build macro: GRAY_ROUND_EN (round-half-up instead of truncation). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gray_frame_loader #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 16,
  parameter int IMAGE_COLUMN_SIZE = 128,
  parameter int IMAGE_ROW_SIZE    = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [3*DATA_WIDTH-1:0] s_rgb_i,
  input  logic                    s_last_i,
  output logic                    wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [DATA_WIDTH-1:0]   wr_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    frame_err_o
);

  localparam int PIXELS = IMAGE_COLUMN_SIZE * IMAGE_ROW_SIZE;
  localparam int SUM_W  = DATA_WIDTH + 9;

  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [SUM_W-1:0]      c_K_R      = SUM_W'(77);
  localparam logic [SUM_W-1:0]      c_K_G      = SUM_W'(150);
  localparam logic [SUM_W-1:0]      c_K_B      = SUM_W'(29);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_start_q;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_frame_err;

  logic                    r_s1_valid;
  logic [SUM_W-1:0]        r_s1_sum;
  logic [ADDR_WIDTH-1:0]   r_s1_addr;

  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;

  logic                    w_start_rise;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_at_last_idx;
  logic                    w_end_beat;
  logic                    w_len_err;
  logic                    w_pipe_empty;
  logic                    w_busy;
  logic                    w_done;
  logic [SUM_W-1:0]        w_sum;
  logic [DATA_WIDTH-1:0]   w_gray;
  logic                    w_unused;

  assign w_start_rise  = start_i & ~r_start_q;
  assign w_ready       = (r_state == ST_LOAD);
  assign w_accept      = s_valid_i & w_ready;
  assign w_at_last_idx = (r_cnt == c_LAST_IDX);
  assign w_end_beat    = w_at_last_idx | s_last_i;
  // Error when the last flag and the last pixel index disagree, in either direction.
  assign w_len_err     = w_at_last_idx ^ s_last_i;
  assign w_pipe_empty  = ~r_s1_valid & ~r_wr_en;

  assign w_sum = SUM_W'(s_rgb_i[3*DATA_WIDTH-1:2*DATA_WIDTH]) * c_K_R
               + SUM_W'(s_rgb_i[2*DATA_WIDTH-1:DATA_WIDTH])   * c_K_G
               + SUM_W'(s_rgb_i[DATA_WIDTH-1:0])              * c_K_B;

`ifdef GRAY_ROUND_EN
  localparam logic [SUM_W-1:0] c_HALF = SUM_W'(128);
  logic [SUM_W-1:0] w_sum_rnd;
  // Weights sum to 256, so the rounded sum still fits below bit SUM_W-1.
  assign w_sum_rnd = r_s1_sum + c_HALF;
  assign w_gray    = w_sum_rnd[DATA_WIDTH+7:8];
  assign w_unused  = ^{w_sum_rnd[SUM_W-1], w_sum_rnd[7:0]};
`else
  assign w_gray    = r_s1_sum[DATA_WIDTH+7:8];
  assign w_unused  = ^{r_s1_sum[SUM_W-1], r_s1_sum[7:0]};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_busy = 1'b1;
        if (w_accept && w_end_beat) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_busy = 1'b1;
        if (w_pipe_empty) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= start_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_start_rise) begin
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + ADDR_WIDTH'(1);
      if (w_len_err) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sum  <= w_sum;
        r_s1_addr <= r_cnt;
      end
    end
  end

  // Address and data are forced to zero whenever no write is presented.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= r_s1_valid;
      r_wr_addr <= r_s1_valid ? r_s1_addr : '0;
      r_wr_data <= r_s1_valid ? w_gray    : '0;
    end
  end

  assign s_ready_o   = w_ready;
  assign wr_en_o     = r_wr_en;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign busy_o      = w_busy;
  assign done_o      = w_done;
  assign frame_err_o = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_gray_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gray_frame_loader                                                       |
// | Directed bench for gray_frame_loader on a 4x4 frame.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gray_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_rgb;
  logic        s_last;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        frame_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int wa[$];
  int wd[$];
  int wc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int overlap  = 0;
  int idle_nz  = 0;

  gray_frame_loader #(
    .DATA_WIDTH       (8),
    .ADDR_WIDTH       (16),
    .IMAGE_COLUMN_SIZE(4),
    .IMAGE_ROW_SIZE   (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_rgb_i    (s_rgb),
    .s_last_i   (s_last),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .busy_o     (busy),
    .done_o     (done),
    .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write / done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
      wc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      if (wr_en === 1'b1) overlap = overlap + 1;
    end
    if (wr_en === 1'b0 && (wr_addr !== 16'd0 || wr_data !== 8'd0)) idle_nz = idle_nz + 1;
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    done_cnt = 0;
    overlap  = 0;
    idle_nz  = 0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one beat for one edge; returns the cycle index of the accepting edge.
  task automatic drive_beat(input logic [23:0] rgb, input logic last, output int acc);
    s_valid = 1'b1;
    s_rgb   = rgb;
    s_last  = last;
    @(negedge clk);
    acc     = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    s_valid = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: done_o seen=%0d, required 1 within %0d cycles", seen, budget);
    end
  endtask

  task automatic check_addrs(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (i >= wa.size()) begin
        n_err++;
        $display("FAIL %s_addr[%0d]: no write recorded, required addr %0d", tag, i, i);
      end else if (wa[i] !== i) begin
        n_err++;
        $display("FAIL %s_addr[%0d]: got %0d, required %0d", tag, i, wa[i], i);
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_rgb   = 24'd0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({s_ready, wr_en, wr_addr, wr_data, busy, done, frame_err} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, required 0",
               {s_ready, wr_en, wr_addr, wr_data, busy, done, frame_err});
    end
    rst_n = 1'b1;
    idle(2);
    n_vec++;
    if ({s_ready, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_no_start: ready/busy got %b, required 00", {s_ready, busy});
    end
  endtask

  task automatic test_full_frame();
    int acc0;
    int a;
    clear_log();
    pulse_start();
    n_vec++;
    if ({busy, s_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL load_entry: busy/ready got %b, required 11", {busy, s_ready});
    end
    for (int i = 0; i < 16; i++) begin
      drive_beat(24'hFFFFFF, i == 15, a);
      if (i == 0) acc0 = a;
    end
    wait_done(20);
    idle(4);
    n_vec++;
    if (wa.size() !== 16) begin
      n_err++;
      $display("FAIL full_count: got %0d writes, required 16", wa.size());
    end
    check_addrs("full", 16);
    for (int i = 0; i < 16 && i < wd.size(); i++) begin
      n_vec++;
      if (wd[i] !== 255) begin
        n_err++;
        $display("FAIL full_data[%0d]: got %0d, required 255", i, wd[i]);
      end
    end
    n_vec++;
    if (wc.size() == 0 || wc[0] !== acc0 + 1) begin
      n_err++;
      $display("FAIL full_latency: first write cycle got %0d, required %0d",
               (wc.size() == 0) ? -1 : wc[0], acc0 + 1);
    end
    n_vec++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL full_done_count: got %0d, required 1", done_cnt);
    end
    n_vec++;
    if (wc.size() == 0 || done_cyc <= wc[wc.size()-1] || overlap !== 0) begin
      n_err++;
      $display("FAIL full_done_order: done cycle %0d overlap %0d, required after last write with 0 overlap",
               done_cyc, overlap);
    end
    n_vec++;
    if (idle_nz !== 0) begin
      n_err++;
      $display("FAIL idle_bus_zero: got %0d nonzero idle samples, required 0", idle_nz);
    end
    n_vec++;
    if ({frame_err, busy, s_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL full_end_state: err/busy/ready got %b, required 000", {frame_err, busy, s_ready});
    end
  endtask

  task automatic test_gray_values();
    int a;
    int exp_d[4] = '{62, 1, 149, 0};
    clear_log();
    pulse_start();
    drive_beat({8'd100, 8'd50, 8'd25}, 1'b0, a);
    drive_beat({8'd1, 8'd1, 8'd1}, 1'b0, a);
    drive_beat({8'd0, 8'd255, 8'd0}, 1'b0, a);
    drive_beat({8'd0, 8'd0, 8'd0}, 1'b1, a);
    wait_done(20);
    idle(3);
    n_vec++;
    if (wa.size() !== 4) begin
      n_err++;
      $display("FAIL gray_count: got %0d writes, required 4", wa.size());
    end
    for (int i = 0; i < 4 && i < wd.size(); i++) begin
      n_vec++;
      if (wd[i] !== exp_d[i]) begin
        n_err++;
        $display("FAIL gray_data[%0d]: got %0d, required %0d", i, wd[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_valid_toggle();
    int acc[4];
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      drive_beat({8'(i * 40), 8'(i * 20), 8'(i * 10)}, i == 3, acc[i]);
      if (i != 3) idle(1);
    end
    wait_done(20);
    idle(3);
    n_vec++;
    if (wa.size() !== 4) begin
      n_err++;
      $display("FAIL toggle_count: got %0d writes, required 4", wa.size());
    end
    check_addrs("toggle", 4);
    for (int i = 0; i < 4 && i < wc.size(); i++) begin
      n_vec++;
      if (wc[i] !== acc[i] + 1) begin
        n_err++;
        $display("FAIL toggle_timing[%0d]: write cycle got %0d, required %0d", i, wc[i], acc[i] + 1);
      end
    end
  endtask

  task automatic test_frame_errors();
    int a;
    clear_log();
    pulse_start();
    for (int i = 0; i < 6; i++) drive_beat(24'h102030, i == 5, a);
    wait_done(20);
    idle(3);
    n_vec++;
    if (wa.size() !== 6 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL early_last: got %0d writes %0d done, required 6 writes 1 done", wa.size(), done_cnt);
    end
    check_addrs("early", 6);
    n_vec++;
    if (frame_err !== 1'b1) begin
      n_err++;
      $display("FAIL early_err: got %b, required 1", frame_err);
    end
    pulse_start();
    n_vec++;
    if (frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: got %b, required 0", frame_err);
    end
    clear_log();
    for (int i = 0; i < 16; i++) drive_beat(24'h405060, 1'b0, a);
    wait_done(20);
    idle(3);
    n_vec++;
    if (wa.size() !== 16 || done_cnt !== 1 || frame_err !== 1'b1) begin
      n_err++;
      $display("FAIL missing_last: got %0d writes %0d done err %b, required 16 writes 1 done err 1",
               wa.size(), done_cnt, frame_err);
    end
  endtask

  task automatic test_reset_midframe();
    int a;
    clear_log();
    pulse_start();
    for (int i = 0; i < 8; i++) drive_beat(24'h808080, 1'b0, a);
    #1;
    n_vec++;
    if (wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_write: wr_en got %b, required 1", wr_en);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_ready, wr_en, wr_addr, wr_data, busy, done, frame_err} !== 30'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h, required 0",
               {s_ready, wr_en, wr_addr, wr_data, busy, done, frame_err});
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (wa.size() !== 7 || done_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_stop: got %0d writes %0d done, required 7 writes 0 done", wa.size(), done_cnt);
    end
    rst_n = 1'b1;
    idle(3);
    n_vec++;
    if ({busy, s_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_no_restart: busy/ready got %b, required 00", {busy, s_ready});
    end
    clear_log();
    pulse_start();
    for (int i = 0; i < 16; i++) drive_beat(24'h010203, i == 15, a);
    wait_done(20);
    idle(3);
    n_vec++;
    if (wa.size() !== 16 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL reload: got %0d writes %0d done, required 16 writes 1 done", wa.size(), done_cnt);
    end
    check_addrs("reload", 16);
  endtask

  task automatic test_start_in_load();
    int a;
    clear_log();
    pulse_start();
    for (int i = 0; i < 3; i++) drive_beat(24'h203040, 1'b0, a);
    idle(1);
    pulse_start();
    n_vec++;
    if ({busy, s_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL start_in_load_state: busy/ready got %b, required 11", {busy, s_ready});
    end
    for (int i = 3; i < 16; i++) drive_beat(24'h203040, i == 15, a);
    wait_done(20);
    idle(3);
    n_vec++;
    if (wa.size() !== 16 || done_cnt !== 1 || frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_load: got %0d writes %0d done err %b, required 16 writes 1 done err 0",
               wa.size(), done_cnt, frame_err);
    end
    check_addrs("restart_ignored", 16);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gray_values();
    test_valid_toggle();
    test_frame_errors();
    test_reset_midframe();
    test_start_in_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
